// File: rtl/rob_multi_wb.sv
// Reorder buffer with multiple writeback channels, operand lookup with writeback bypass,
// store-commit handshake and a registered misprediction flush/redirect.
module rob_multi_wb #(
    parameter int DEPTH   = 16,
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int NUM_WB  = 2,
    parameter int TAG_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [1:0]                alloc_kind,
    input  logic [RADDR_W-1:0]        alloc_rd,
    input  logic [XLEN-1:0]           alloc_pc,
    input  logic [XLEN-1:0]           alloc_pjt,
    output logic [TAG_W-1:0]          alloc_tag,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]   wb_tag,
    input  logic [NUM_WB*XLEN-1:0]    wb_val,
    input  logic [NUM_WB*XLEN-1:0]    wb_jt,
    input  logic [TAG_W-1:0]          lk_tag1,
    input  logic [TAG_W-1:0]          lk_tag2,
    output logic                      lk_rdy1,
    output logic                      lk_rdy2,
    output logic [XLEN-1:0]           lk_val1,
    output logic [XLEN-1:0]           lk_val2,
    output logic                      cm_en,
    output logic [RADDR_W-1:0]        cm_rd,
    output logic [TAG_W-1:0]          cm_tag,
    output logic [XLEN-1:0]           cm_val,
    output logic                      st_valid,
    output logic [TAG_W-1:0]          st_tag,
    input  logic                      st_ready,
    output logic                      flush,
    output logic [XLEN-1:0]           redirect_pc,
    output logic [TAG_W-1:0]          count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [1:0] K_STORE  = 2'd1;
    localparam logic [1:0] K_BRANCH = 2'd2;

    logic [DEPTH-1:0]   valid_q, rdy_q;
    logic [1:0]         kind_q [DEPTH];
    logic [RADDR_W-1:0] rd_q   [DEPTH];
    logic [XLEN-1:0]    pc_q   [DEPTH];
    logic [XLEN-1:0]    pjt_q  [DEPTH];
    logic [XLEN-1:0]    val_q  [DEPTH];
    logic [XLEN-1:0]    jt_q   [DEPTH];

    logic [IDX_W-1:0]   head_q, tail_q;
    logic [TAG_W-1:0]   count_q;
    logic               cm_en_q, flush_q;
    logic [RADDR_W-1:0] cm_rd_q;
    logic [TAG_W-1:0]   cm_tag_q;
    logic [XLEN-1:0]    cm_val_q, redirect_q;

    logic               empty, full, active, pop, cm_fire, mispred, alloc_fire;
    logic [1:0]         head_kind;
    logic [TAG_W-1:0]   head_tag;
    logic               unused_pc;

    function automatic logic tag_ok(input logic [TAG_W-1:0] t);
        return (t != '0) && (t <= TAG_W'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] slot_of(input logic [TAG_W-1:0] t);
        logic [TAG_W-1:0] s;
        s = t - TAG_W'(1);
        return s[IDX_W-1:0];
    endfunction

    // Bypass from this cycle's writebacks takes priority over stored state; lowest channel wins.
    function automatic logic [XLEN:0] lookup(input logic [TAG_W-1:0] t);
        logic [XLEN:0] r;
        logic          found;
        r     = '0;
        found = 1'b0;
        if (t == '0) begin
            r = {1'b1, {XLEN{1'b0}}};
        end else begin
            for (int c = 0; c < NUM_WB; c++) begin
                if (!found && wb_valid[c] && wb_tag[c*TAG_W +: TAG_W] == t) begin
                    found = 1'b1;
                    r     = {1'b1, wb_val[c*XLEN +: XLEN]};
                end
            end
            if (!found && tag_ok(t) && valid_q[slot_of(t)])
                r = {rdy_q[slot_of(t)], val_q[slot_of(t)]};
        end
        return r;
    endfunction

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == TAG_W'(DEPTH));
        active     = en && !flush_q && !empty;
        head_kind  = kind_q[head_q];
        head_tag   = TAG_W'(head_q) + TAG_W'(1);
        pop        = active && ((head_kind == K_STORE) ? st_ready : rdy_q[head_q]);
        cm_fire    = pop && (head_kind != K_STORE) && (head_kind != K_BRANCH);
        mispred    = pop && (head_kind == K_BRANCH) && (jt_q[head_q] != pjt_q[head_q]);
        alloc_fire = alloc_valid && alloc_ready && en;
        {lk_rdy1, lk_val1} = lookup(lk_tag1);
        {lk_rdy2, lk_val2} = lookup(lk_tag2);
    end

    assign alloc_ready = !full && !flush_q;
    assign alloc_tag   = TAG_W'(tail_q) + TAG_W'(1);
    assign st_valid    = active && (head_kind == K_STORE);
    assign st_tag      = head_tag;
    assign cm_en       = cm_en_q;
    assign cm_rd       = cm_rd_q;
    assign cm_tag      = cm_tag_q;
    assign cm_val      = cm_val_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_q;
    assign count       = count_q;
    // The PC is carried per entry for debug visibility only.
    assign unused_pc   = ^pc_q[head_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            rdy_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            cm_en_q    <= 1'b0;
            flush_q    <= 1'b0;
            cm_rd_q    <= '0;
            cm_tag_q   <= '0;
            cm_val_q   <= '0;
            redirect_q <= '0;
        end else if (en) begin
            cm_en_q <= cm_fire;
            flush_q <= mispred;
            if (cm_fire) begin
                cm_rd_q  <= rd_q[head_q];
                cm_tag_q <= head_tag;
                cm_val_q <= val_q[head_q];
            end
            if (mispred) begin
                redirect_q <= jt_q[head_q];
                valid_q    <= '0;
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
            end else begin
                if (!flush_q) begin
                    for (int c = NUM_WB - 1; c >= 0; c--) begin
                        if (wb_valid[c] && tag_ok(wb_tag[c*TAG_W +: TAG_W]) &&
                            valid_q[slot_of(wb_tag[c*TAG_W +: TAG_W])]) begin
                            rdy_q[slot_of(wb_tag[c*TAG_W +: TAG_W])] <= 1'b1;
                            val_q[slot_of(wb_tag[c*TAG_W +: TAG_W])] <= wb_val[c*XLEN +: XLEN];
                            jt_q[slot_of(wb_tag[c*TAG_W +: TAG_W])]  <= wb_jt[c*XLEN +: XLEN];
                        end
                    end
                end
                if (pop) begin
                    valid_q[head_q] <= 1'b0;
                    head_q          <= head_q + IDX_W'(1);
                end
                if (alloc_fire) begin
                    valid_q[tail_q] <= 1'b1;
                    rdy_q[tail_q]   <= 1'b0;
                    val_q[tail_q]   <= '0;
                    kind_q[tail_q]  <= alloc_kind;
                    rd_q[tail_q]    <= alloc_rd;
                    pc_q[tail_q]    <= alloc_pc;
                    pjt_q[tail_q]   <= alloc_pjt;
                    tail_q          <= tail_q + IDX_W'(1);
                end
                count_q <= count_q + TAG_W'(alloc_fire) - TAG_W'(pop);
            end
        end else begin
            cm_en_q <= 1'b0;
            flush_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rob_multi_wb.sv
// Directed self-checking bench for rob_multi_wb (DEPTH=16, two writeback channels).
module tb_rob_multi_wb;
    localparam int DEPTH = 16, XLEN = 32, RADDR_W = 5, NUM_WB = 2, TAG_W = 5;

    logic clk = 0, rst, en;
    logic alloc_valid, alloc_ready;
    logic [1:0] alloc_kind;
    logic [RADDR_W-1:0] alloc_rd;
    logic [XLEN-1:0] alloc_pc, alloc_pjt;
    logic [TAG_W-1:0] alloc_tag;
    logic [NUM_WB-1:0] wb_valid;
    logic [NUM_WB*TAG_W-1:0] wb_tag;
    logic [NUM_WB*XLEN-1:0] wb_val, wb_jt;
    logic [TAG_W-1:0] lk_tag1, lk_tag2;
    logic lk_rdy1, lk_rdy2;
    logic [XLEN-1:0] lk_val1, lk_val2;
    logic cm_en;
    logic [RADDR_W-1:0] cm_rd;
    logic [TAG_W-1:0] cm_tag;
    logic [XLEN-1:0] cm_val;
    logic st_valid, st_ready, flush;
    logic [TAG_W-1:0] st_tag, count;
    logic [XLEN-1:0] redirect_pc;

    int checks = 0, errors = 0;

    rob_multi_wb #(.DEPTH(DEPTH), .XLEN(XLEN), .RADDR_W(RADDR_W), .NUM_WB(NUM_WB)) dut (
        .clk(clk), .rst(rst), .en(en),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_kind(alloc_kind),
        .alloc_rd(alloc_rd), .alloc_pc(alloc_pc), .alloc_pjt(alloc_pjt), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val), .wb_jt(wb_jt),
        .lk_tag1(lk_tag1), .lk_tag2(lk_tag2), .lk_rdy1(lk_rdy1), .lk_rdy2(lk_rdy2),
        .lk_val1(lk_val1), .lk_val2(lk_val2),
        .cm_en(cm_en), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_val(cm_val),
        .st_valid(st_valid), .st_tag(st_tag), .st_ready(st_ready),
        .flush(flush), .redirect_pc(redirect_pc), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_wb();
        wb_valid = '0; wb_tag = '0; wb_val = '0; wb_jt = '0;
    endtask

    task automatic set_wb(input int ch, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v,
                          input logic [XLEN-1:0] jt);
        wb_valid[ch] = 1'b1;
        wb_tag[ch*TAG_W +: TAG_W] = t;
        wb_val[ch*XLEN +: XLEN] = v;
        wb_jt[ch*XLEN +: XLEN] = jt;
    endtask

    task automatic do_alloc(input logic [1:0] k, input logic [RADDR_W-1:0] rd, input logic [XLEN-1:0] pjt);
        alloc_valid = 1'b1; alloc_kind = k; alloc_rd = rd;
        alloc_pc = 32'h1000 + {27'd0, rd}; alloc_pjt = pjt;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1; en = 1; alloc_valid = 0; alloc_kind = 0; alloc_rd = 0; alloc_pc = 0; alloc_pjt = 0;
        lk_tag1 = 0; lk_tag2 = 0; st_ready = 0;
        clear_wb();
        do_reset();

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_cm_en", cm_en, 0);
        chk("rst_flush", flush, 0);
        chk("rst_cm_rd", cm_rd, 0);
        chk("rst_cm_val", cm_val, 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_tag", alloc_tag, 1);
        chk("rst_st_valid", st_valid, 0);

        // Three ALU ops, out-of-order writeback, in-order commit
        for (int i = 1; i <= 3; i++) begin
            alloc_valid = 1; alloc_kind = 0; alloc_rd = RADDR_W'(i); alloc_pjt = 0;
            settle();
            chk("alloc_tag_seq", alloc_tag, i);
            step();
        end
        alloc_valid = 0;
        chk("count_3", count, 3);
        set_wb(0, 5'd2, 32'h22, 0);
        step();
        clear_wb();
        chk("no_commit_wb2", cm_en, 0);
        step();
        chk("no_commit_wb2_b", cm_en, 0);
        set_wb(1, 5'd1, 32'h11, 0);
        step();
        clear_wb();
        chk("commit_lat_0", cm_en, 0);
        step();
        chk("cm1_en", cm_en, 1);
        chk("cm1_rd", cm_rd, 1);
        chk("cm1_tag", cm_tag, 1);
        chk("cm1_val", cm_val, 32'h11);
        step();
        chk("cm2_en", cm_en, 1);
        chk("cm2_rd", cm_rd, 2);
        chk("cm2_val", cm_val, 32'h22);
        step();
        chk("cm3_wait", cm_en, 0);
        chk("count_1", count, 1);

        // Fill to DEPTH, commit while full, wrap tag
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_alloc(2'd0, RADDR_W'(i + 1), 0);
        chk("full_ready", alloc_ready, 0);
        chk("full_count", count, 16);
        set_wb(0, 5'd1, 32'h1, 0);
        step();
        clear_wb();
        alloc_valid = 1; alloc_kind = 0; alloc_rd = 5'd20;
        settle();
        chk("full_ready_commit", alloc_ready, 0);
        step();
        chk("full_pop_count", count, 15);
        chk("full_pop_cm", cm_en, 1);
        chk("wrap_ready", alloc_ready, 1);
        chk("wrap_tag", alloc_tag, 1);
        step();
        alloc_valid = 0;
        chk("wrap_count", count, 16);

        // Dual writeback to the same tag, lookup bypass and tag 0
        set_wb(0, 5'd5, 32'hA, 0);
        set_wb(1, 5'd5, 32'hB, 0);
        lk_tag1 = 5'd5; lk_tag2 = 5'd0;
        settle();
        chk("lk1_byp_rdy", lk_rdy1, 1);
        chk("lk1_byp_val", lk_val1, 32'hA);
        chk("lk2_zero_rdy", lk_rdy2, 1);
        chk("lk2_zero_val", lk_val2, 0);
        step();
        clear_wb();
        lk_tag2 = 5'd6;
        settle();
        chk("lk1_stored_rdy", lk_rdy1, 1);
        chk("lk1_stored_val", lk_val1, 32'hA);
        chk("lk2_notready", lk_rdy2, 0);
        set_wb(1, 5'd6, 32'h66, 0);
        settle();
        chk("lk2_ch1_byp", lk_val2, 32'h66);
        clear_wb();
        lk_tag1 = 0; lk_tag2 = 0;

        // Store at head holds younger ready ALU
        do_reset();
        do_alloc(2'd1, 5'd0, 0);
        do_alloc(2'd0, 5'd7, 0);
        set_wb(0, 5'd2, 32'h77, 0);
        step();
        clear_wb();
        for (int i = 0; i < 3; i++) begin
            chk("st_valid_hold", st_valid, 1);
            chk("st_tag_hold", st_tag, 1);
            chk("st_no_cm", cm_en, 0);
            chk("st_count_hold", count, 2);
            step();
        end
        en = 0;
        st_ready = 1;
        settle();
        chk("st_valid_en0", st_valid, 0);
        step();
        chk("st_en0_count", count, 2);
        en = 1;
        settle();
        chk("st_valid_again", st_valid, 1);
        step();
        st_ready = 0;
        chk("st_pop_count", count, 1);
        chk("st_pop_cm", cm_en, 0);
        chk("st_after_pop", st_valid, 0);
        step();
        chk("alu_after_st_en", cm_en, 1);
        chk("alu_after_st_rd", cm_rd, 7);
        chk("alu_after_st_tag", cm_tag, 2);
        chk("alu_after_st_val", cm_val, 32'h77);
        chk("alu_after_st_cnt", count, 0);

        // Branch misprediction flush
        do_reset();
        do_alloc(2'd2, 5'd0, 32'h100);
        for (int i = 0; i < 4; i++) do_alloc(2'd0, RADDR_W'(i + 8), 0);
        set_wb(0, 5'd1, 32'h0, 32'h200);
        step();
        clear_wb();
        alloc_valid = 1; alloc_kind = 0; alloc_rd = 5'd30;
        settle();
        chk("br_pre_ready", alloc_ready, 1);
        step();
        chk("br_flush", flush, 1);
        chk("br_redirect", redirect_pc, 32'h200);
        chk("br_count", count, 0);
        chk("br_ready_flush", alloc_ready, 0);
        step();
        chk("br_flush_drop", flush, 0);
        chk("br_count_after", count, 0);
        chk("br_next_tag", alloc_tag, 1);
        step();
        alloc_valid = 0;
        chk("br_alloc_count", count, 1);
        chk("br_alloc_tag2", alloc_tag, 2);

        // Reset overrides a pending flush
        do_reset();
        do_alloc(2'd2, 5'd0, 32'h100);
        for (int i = 0; i < 7; i++) do_alloc(2'd0, RADDR_W'(i + 1), 0);
        chk("half_count", count, 8);
        set_wb(0, 5'd1, 32'h0, 32'h300);
        step();
        clear_wb();
        rst = 1;
        step();
        chk("rst_ovr_flush", flush, 0);
        chk("rst_ovr_count", count, 0);
        chk("rst_ovr_cm_en", cm_en, 0);
        chk("rst_ovr_redir", redirect_pc, 0);
        rst = 0;
        step();
        chk("rst_ovr_tag", alloc_tag, 1);
        chk("rst_ovr_flush2", flush, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_multi_wb.md
Name: rob_multi_wb

Overview:
- Parametrised reorder buffer, successor to the single-writeback ROB.
- Configurable depth, data width and number of writeback channels (ALU/LSB/extra units).
- Adds a ready/valid store-commit handshake, combinational operand lookup with writeback bypass, an occupancy count, and a registered flush/redirect on branch misprediction.
- Sits between issue/rename (alloc), execution units (wb), the register file (commit) and IF (redirect).

Parameters:
DEPTH, 16, entry count; power of two, >=4
XLEN, 32, data/PC width
RADDR_W, 5, architectural register index width
NUM_WB, 2, writeback channels
TAG_W, $clog2(DEPTH+1), tag width; tag = slot+1, tag 0 = "no dependency"

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  global enable; 0 freezes all state
alloc_valid  in  1  new instruction request
alloc_ready  out  1  !full && !flush (combinational)
alloc_kind  in  2  0 ALU, 1 STORE, 2 BRANCH/JUMP
alloc_rd  in  RADDR_W  destination register
alloc_pc  in  XLEN  instruction PC
alloc_pjt  in  XLEN  predicted target
alloc_tag  out  TAG_W  tag the next allocation receives (tail+1)
wb_valid  in  NUM_WB  per-channel result valid
wb_tag  in  NUM_WB*TAG_W  flattened result tags
wb_val  in  NUM_WB*XLEN  flattened result values
wb_jt  in  NUM_WB*XLEN  flattened actual jump targets
lk_tag1, lk_tag2  in  TAG_W  operand tags to resolve
lk_rdy1, lk_rdy2  out  1  operand available (combinational)
lk_val1, lk_val2  out  XLEN  operand value
cm_en  out  1  register commit pulse (registered)
cm_rd  out  RADDR_W  committed rd
cm_tag  out  TAG_W  committed tag
cm_val  out  XLEN  committed value
st_valid  out  1  head is a store awaiting commit (combinational)
st_tag  out  TAG_W  tag of that store
st_ready  in  1  LSB accepts store commit
flush  out  1  misprediction flush pulse (registered)
redirect_pc  out  XLEN  correct PC, valid with flush
count  out  TAG_W  occupied entries

Behaviour:
- Reset: all entries invalid; head=tail=0; count=0. cm_en, flush, cm_rd, cm_tag, cm_val and redirect_pc are 0.
- Allocation is accepted when alloc_valid && alloc_ready && en.
  - Writes kind, rd, pc and pjt into slot tail; clears rdy and val.
  - tail wraps modulo DEPTH; count+1.
  - full = (count==DEPTH). At full, allocation is refused even if the same cycle commits.
- Writeback: each channel with wb_valid and a tag mapping to a valid entry sets rdy and stores val and jt.
  - Tag 0 or a tag for an invalid entry is ignored.
  - Same tag on several channels: lowest channel index wins.
- Lookup:
  - tag 0 -> rdy=1, val=0.
  - Otherwise, a matching wb channel this cycle (lowest index first) -> rdy=1, val=wb_val.
  - Otherwise, stored rdy/val. An invalid entry -> rdy=0.
- Commit: at most one per cycle, at head, only while en && !flush.
  - STORE: st_valid=1 and st_tag=head+1 irrespective of rdy. Pop on st_ready. No cm_en.
  - ALU with rdy: cm_en=1 next cycle with rd, tag and val. Pop.
  - BRANCH with rdy: pop. If jt != pjt, flush=1 and redirect_pc=jt next cycle, and all entries are invalidated at that edge: head=tail=0, count=0. An allocation in the same cycle is discarded.
- Simultaneous alloc+commit: count unchanged. Empty: no commit; st_valid=0.
- During a flush cycle: alloc_ready=0; writebacks are ignored; flush drops after one cycle.
- en=0: no state change; registered pulses (cm_en, flush) are forced 0; st_valid=0.
- rst mid-operation overrides everything, including a pending flush.

Test Plan:
- Reset, then allocate 3 ALU ops (rd 1,2,3) -> alloc_tag sequence 1,2,3, count=3. wb tag2=0x22 -> no commit. wb tag1=0x11 -> cm_en rd=1 val=0x11, then rd=2 val=0x22 on consecutive cycles.
- DEPTH=16: fill 16 entries -> alloc_ready=0, count=16. Commit one while alloc_valid held -> no allocation that cycle. Next cycle allocation gets tag 1 (wrap).
- Both wb channels hit tag 5 with 0xA and 0xB, and lk_tag1=5 -> lk_rdy1=1, lk_val1=0xA; entry stores 0xA. lk_tag2=0 -> rdy=1, val=0.
- Store at head: st_valid=1, st_ready=0 for 3 cycles -> head holds, younger ready ALU not committed. st_ready=1 -> pop, ALU commits next cycle.
- Branch pjt=0x100, wb jt=0x200 with 4 younger entries -> flush=1, redirect_pc=0x200 for one cycle, count=0, alloc_ready=0 during flush. Next allocation gets tag 1.
- Assert rst while the buffer is half full and a flush is pending -> next cycle flush=0, count=0, cm_en=0.
